// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA/DVI raster timing generator.
// Issues pixel-coordinate requests SHIFT_ACTIVE cycles ahead of scan-out and
// registers the returned colour onto vga_rgb, aligned with vga_de/hs/vs.
// Optional build macro VGA_TEST_PATTERN_EN replaces color_in with 8 vertical
// colour bars (white, yellow, cyan, green, magenta, red, blue, black).
module vga_timing_gen #(
  parameter int H_VISIBLE    = 1024,
  parameter int H_FRONT      = 24,
  parameter int H_SYNC       = 136,
  parameter int H_BACK       = 160,
  parameter int V_VISIBLE    = 768,
  parameter int V_FRONT      = 3,
  parameter int V_SYNC       = 6,
  parameter int V_BACK       = 29,
  parameter int HS_POL       = 0,
  parameter int VS_POL       = 0,
  parameter int SHIFT_ACTIVE = 4,
  parameter int X_W          = 10,
  parameter int Y_W          = 10,
  parameter int COLOR_W      = 24
) (
  input  logic               clk65,
  input  logic               rst_n,
  input  logic [COLOR_W-1:0] color_in,
  output logic               active,
  output logic [X_W-1:0]     active_x,
  output logic [Y_W-1:0]     active_y,
  output logic               screenend,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_de,
  output logic [COLOR_W-1:0] vga_rgb
);

  localparam int H_LINE  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_FRAME = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HC_W    = $clog2(H_LINE);
  localparam int VC_W    = $clog2(V_FRAME);

  localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_LINE - 1);
  localparam logic [HC_W-1:0] H_VIS    = HC_W'(H_VISIBLE);
  localparam logic [HC_W-1:0] HS_START = HC_W'(H_VISIBLE + H_FRONT);
  localparam logic [HC_W-1:0] HS_END   = HC_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_FRAME - 1);
  localparam logic [VC_W-1:0] V_VIS    = VC_W'(V_VISIBLE);
  localparam logic [VC_W-1:0] VS_START = VC_W'(V_VISIBLE + V_FRONT);
  localparam logic [VC_W-1:0] VS_END   = VC_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [X_W-1:0]  X_LAST   = X_W'(H_VISIBLE - 1);
  localparam logic [Y_W-1:0]  Y_LAST   = Y_W'(V_VISIBLE - 1);
  localparam logic            HS_ACT   = 1'(HS_POL);
  localparam logic            VS_ACT   = 1'(VS_POL);

  // Elaboration-time parameter sanity checks
  if (SHIFT_ACTIVE < 1 || SHIFT_ACTIVE > 16) begin : g_bad_shift
    $error("vga_timing_gen: SHIFT_ACTIVE must be in 1..16");
  end
  if ((H_VISIBLE - 1) >= (2 ** X_W)) begin : g_bad_xw
    $error("vga_timing_gen: X_W too narrow for H_VISIBLE-1");
  end
  if ((V_VISIBLE - 1) >= (2 ** Y_W)) begin : g_bad_yw
    $error("vga_timing_gen: Y_W too narrow for V_VISIBLE-1");
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_PIX = (H_VISIBLE / 8 > 0) ? H_VISIBLE / 8 : 1;
  localparam int CH_W    = COLOR_W / 3;

  // Colour of the vertical bar containing column x, full scale per channel
  function automatic logic [COLOR_W-1:0] bar_color(input logic [X_W-1:0] x);
    logic [COLOR_W-1:0] c;
    logic [2:0]         rgb;
    int                 idx;
    idx = int'(x) / BAR_PIX;
    case (idx)
      0:       rgb = 3'b111;
      1:       rgb = 3'b110;
      2:       rgb = 3'b011;
      3:       rgb = 3'b010;
      4:       rgb = 3'b101;
      5:       rgb = 3'b100;
      6:       rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
    c = '0;
    c[3*CH_W-1 -: CH_W] = {CH_W{rgb[2]}};
    c[2*CH_W-1 -: CH_W] = {CH_W{rgb[1]}};
    c[CH_W-1   -: CH_W] = {CH_W{rgb[0]}};
    return c;
  endfunction
`endif

  logic [HC_W-1:0] h_cnt;
  logic [VC_W-1:0] v_cnt;
  logic            vis_c;
  logic            hs_raw;
  logic            vs_raw;
  logic            hs_p0;
  logic            vs_p0;

  logic            vld_dly [SHIFT_ACTIVE];
  logic            hs_dly  [SHIFT_ACTIVE];
  logic            vs_dly  [SHIFT_ACTIVE];
  logic            vld_pre;
  logic [COLOR_W-1:0] pix_color;

  assign vis_c  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_raw = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_raw = (v_cnt >= VS_START) && (v_cnt < VS_END);

  // Raster counters: h_cnt per pixel, v_cnt advances on each line wrap
  always_ff @(posedge clk65 or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Stage 0: coordinate request and raw sync, one cycle behind the counters
  always_ff @(posedge clk65 or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      active_x <= '0;
      active_y <= '0;
      hs_p0    <= 1'b0;
      vs_p0    <= 1'b0;
    end else begin
      active   <= vis_c;
      active_x <= vis_c ? X_W'(h_cnt) : '0;
      active_y <= vis_c ? Y_W'(v_cnt) : '0;
      hs_p0    <= hs_raw;
      vs_p0    <= vs_raw;
    end
  end

  // End-of-visible-frame pulse, one cycle after the last visible request
  always_ff @(posedge clk65 or negedge rst_n) begin
    if (!rst_n) begin
      screenend <= 1'b0;
    end else begin
      screenend <= active && (active_x == X_LAST) && (active_y == Y_LAST);
    end
  end

  // Stage 1..SHIFT_ACTIVE: delay line carrying valid and raw syncs to scan-out
  always_ff @(posedge clk65 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SHIFT_ACTIVE; i++) begin
        vld_dly[i] <= 1'b0;
        hs_dly[i]  <= 1'b0;
        vs_dly[i]  <= 1'b0;
      end
    end else begin
      vld_dly[0] <= active;
      hs_dly[0]  <= hs_p0;
      vs_dly[0]  <= vs_p0;
      for (int i = 1; i < SHIFT_ACTIVE; i++) begin
        vld_dly[i] <= vld_dly[i-1];
        hs_dly[i]  <= hs_dly[i-1];
        vs_dly[i]  <= vs_dly[i-1];
      end
    end
  end

  // The valid bit entering the last delay stage gates the colour capture,
  // so vga_rgb and vga_de update on the same edge.
`ifdef VGA_TEST_PATTERN_EN
  logic [X_W-1:0] x_dly [SHIFT_ACTIVE];
  logic [X_W-1:0] x_pre;

  // Column delay line feeding the bar generator, aligned with vld_dly
  always_ff @(posedge clk65 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SHIFT_ACTIVE; i++) x_dly[i] <= '0;
    end else begin
      x_dly[0] <= active_x;
      for (int i = 1; i < SHIFT_ACTIVE; i++) x_dly[i] <= x_dly[i-1];
    end
  end

  if (SHIFT_ACTIVE == 1) begin : g_pre1
    assign vld_pre = active;
    assign x_pre   = active_x;
  end else begin : g_pren
    assign vld_pre = vld_dly[SHIFT_ACTIVE-2];
    assign x_pre   = x_dly[SHIFT_ACTIVE-2];
  end
  assign pix_color = bar_color(x_pre);
`else
  if (SHIFT_ACTIVE == 1) begin : g_pre1
    assign vld_pre = active;
  end else begin : g_pren
    assign vld_pre = vld_dly[SHIFT_ACTIVE-2];
  end
  assign pix_color = color_in;
`endif

  // Output colour register: blanking is forced black
  always_ff @(posedge clk65 or negedge rst_n) begin
    if (!rst_n) begin
      vga_rgb <= '0;
    end else if (vld_pre) begin
      vga_rgb <= pix_color;
    end else begin
      vga_rgb <= '0;
    end
  end

  assign vga_de = vld_dly[SHIFT_ACTIVE-1];
  assign vga_hs = ~(hs_dly[SHIFT_ACTIVE-1] ^ HS_ACT);
  assign vga_vs = ~(vs_dly[SHIFT_ACTIVE-1] ^ VS_ACT);

endmodule
